prog_clock_divider: RTL and testbench

Parametrised, programmable clock divider producing a divided square wave or a one-cycle tick from a single fast clock. It supersedes the fixed 4-bit divider with a WIDTH-bit divisor, selectable output mode, glitch-free divisor updates at period boundaries, pause and phase-resynchronisation. All outputs are registered. It sits in the clocking/timebase layer and feeds enables or divided clocks to downstream logic.

---
 rtl/prog_clock_divider.sv | 83 ++++++++
 tb/tb_prog_clock_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: programmable divider emitting a square wave or per-period tick,
// with shadowed divisor updates applied only at period boundaries, pause and phase resync.
module prog_clock_divider #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_active,
    output logic             div_pending
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_count, r_div, r_shadow;
    logic [WIDTH-1:0] w_count, w_div, w_shadow, w_next_div;
    logic             r_pending, r_tick, r_clk;
    logic             w_pending, w_tick, w_clk, w_boundary;
    logic [WIDTH:0]   w_half;
    assign w_next_div = div_load ? div_in : (r_pending ? r_shadow : r_div);
    assign w_boundary = sync_clr || (en && r_count == r_div - 1'b1);
    always_comb begin
        w_state   = r_state;
        w_count   = r_count;
        w_div     = r_div;
        w_shadow  = r_shadow;
        w_pending = r_pending;
        w_tick    = 1'b0;
        if (r_state == IDLE) begin
            w_div = div_load ? div_in : r_div;
            if (en && w_div != '0) begin
                w_state = RUN;
                w_count = '0;
                w_tick  = 1'b1;
            end
        end else if (w_boundary) begin
            w_div     = w_next_div;
            w_pending = 1'b0;
            w_count   = '0;
            w_state   = (w_next_div == '0) ? IDLE : (en ? RUN : PAUSE);
            w_tick    = en && w_next_div != '0;
        end else begin
            w_shadow  = div_load ? div_in : r_shadow;
            w_pending = r_pending || div_load;
            w_count   = en ? r_count + 1'b1 : r_count;
            w_state   = en ? RUN : PAUSE;
        end
    end
    // high half rounds up so odd divisors get the extra high cycle
    assign w_half = ({1'b0, w_div} + 1'b1) >> 1;
    assign w_clk  = (w_state != IDLE) && (mode ? ({1'b0, w_count} < w_half) : w_tick);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_div     <= WIDTH'(RESET_DIV);
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_clk     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_count   <= w_count;
            r_div     <= w_div;
            r_shadow  <= w_shadow;
            r_pending <= w_pending;
            r_tick    <= w_tick;
            r_clk     <= w_clk;
        end
    end
    assign clk_out     = r_clk;
    assign tick        = r_tick;
    assign count       = r_count;
    assign div_active  = r_div;
    assign div_pending = r_pending;
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed scenarios plus a short random burst, checked every
// cycle against a period/phase model and pinned with hand-computed literals.
module tb_prog_clock_divider;
    localparam int W = 8;
    logic         clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0, sync_clr = 1'b0, div_load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         clk_out, tick, div_pending;
    logic [W-1:0] count, div_active;
    int           n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    prog_clock_divider #(.WIDTH(W), .RESET_DIV(0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sync_clr(sync_clr),
        .div_in(div_in), .div_load(div_load), .clk_out(clk_out), .tick(tick),
        .count(count), .div_active(div_active), .div_pending(div_pending)
    );

    typedef struct packed {
        bit act, pend, tk, md;
        int phase, div, shadow;
    } model_t;
    model_t m;

    function automatic model_t step(model_t s, bit e, bit md, bit sc, bit ld, int din);
        int nd;
        nd = ld ? din : (s.pend ? s.shadow : s.div);
        s.md = md;
        if (!s.act) begin
            if (ld) s.div = din;
            s.tk = e && s.div != 0;
            if (s.tk) begin
                s.act   = 1;
                s.phase = 0;
            end
        end else if (sc || (e && s.phase == s.div - 1)) begin
            s.div   = nd;
            s.pend  = 0;
            s.phase = 0;
            s.act   = nd != 0;
            s.tk    = e && nd != 0;
        end else begin
            if (ld) begin
                s.shadow = din;
                s.pend   = 1;
            end
            s.tk = 0;
            if (e) s.phase++;
        end
        return s;
    endfunction

    function automatic bit exp_clk(model_t s);
        return s.act && (s.md ? (s.phase < (s.div + 1) / 2) : s.tk);
    endfunction

    always @(posedge clk or posedge rst)
        m <= rst ? '0 : step(m, en, mode, sync_clr, div_load, int'(div_in));

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("m_count", int'(count), m.phase);
        check("m_tick", int'(tick), int'(m.tk));
        check("m_clk_out", int'(clk_out), int'(exp_clk(m)));
        check("m_div_active", int'(div_active), m.div);
        check("m_div_pending", int'(div_pending), int'(m.pend));
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(int d);
        div_in = W'(d);
        div_load = 1'b1;
        cyc(1);
        div_load = 1'b0;
    endtask

    task automatic sync1();
        sync_clr = 1'b1;
        cyc(1);
        sync_clr = 1'b0;
    endtask

    initial begin
        int acc;
        #12;
        check("rst_count", int'(count), 0);
        check("rst_div", int'(div_active), 0);
        check("rst_pend", int'(div_pending), 0);
        check("rst_clk", int'(clk_out), 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        en = 1'b1;
        mode = 1'b1;
        load(4);
        check("t1_div", int'(div_active), 4);
        check("t1_tick0", int'(tick), 1);
        check("t1_clk0", int'(clk_out), 1);
        cyc(1);
        check("t1_clk1", int'(clk_out), 1);
        cyc(1);
        check("t1_clk2", int'(clk_out), 0);
        cyc(2);
        check("t1_wrap_count", int'(count), 0);
        check("t1_wrap_tick", int'(tick), 1);
        load(5);
        check("t2_pend", int'(div_pending), 1);
        check("t2_div_old", int'(div_active), 4);
        sync1();
        check("t2_div", int'(div_active), 5);
        check("t2_count", int'(count), 0);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            acc += int'(clk_out);
            cyc(1);
        end
        check("t2_n5_high", acc, 3);
        load(1);
        sync1();
        cyc(3);
        check("n1_clk", int'(clk_out), 1);
        check("n1_tick", int'(tick), 1);
        mode = 1'b0;
        load(6);
        check("p6_bypass_div", int'(div_active), 6);
        check("p6_bypass_pend", int'(div_pending), 0);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            acc += int'(clk_out);
            cyc(1);
        end
        check("p6_pulses", acc, 2);
        mode = 1'b1;
        load(8);
        sync1();
        cyc(2);
        load(3);
        check("t3_count", int'(count), 3);
        check("t3_pend", int'(div_pending), 1);
        cyc(4);
        check("t3_still_pend", int'(div_pending), 1);
        check("t3_still_div", int'(div_active), 8);
        cyc(1);
        check("t3_applied", int'(div_active), 3);
        check("t3_pend_clr", int'(div_pending), 0);
        cyc(2);
        load(7);
        check("t3_wrap_load_div", int'(div_active), 7);
        check("t3_wrap_load_pend", int'(div_pending), 0);
        load(10);
        sync1();
        cyc(4);
        en = 1'b0;
        cyc(5);
        check("t4_frozen", int'(count), 4);
        check("t4_tick", int'(tick), 0);
        check("t4_clk", int'(clk_out), 1);
        en = 1'b1;
        cyc(1);
        check("t4_resume", int'(count), 5);
        cyc(5);
        check("t4_period15", int'(count), 0);
        check("t4_period15_tick", int'(tick), 1);
        load(2);
        cyc(5);
        check("t5_count6", int'(count), 6);
        sync1();
        check("t5_sync_count", int'(count), 0);
        check("t5_sync_div", int'(div_active), 2);
        check("t5_sync_tick", int'(tick), 1);
        load(0);
        cyc(1);
        check("t5_idle_div", int'(div_active), 0);
        check("t5_idle_clk", int'(clk_out), 0);
        sync1();
        check("idle_sync_tick", int'(tick), 0);
        en = 1'b0;
        load(4);
        en = 1'b1;
        cyc(2);
        en = 1'b0;
        sync1();
        check("pause_sync_count", int'(count), 0);
        check("pause_sync_tick", int'(tick), 0);
        en = 1'b1;
        cyc(1);
        load(9);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_pend", int'(div_pending), 0);
        check("arst_div", int'(div_active), 0);
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            en       = $urandom_range(0, 9) != 0;
            mode     = (i % 40) < 25;
            sync_clr = $urandom_range(0, 19) == 0;
            div_load = $urandom_range(0, 6) == 0;
            div_in   = W'($urandom_range(0, 7));
            cyc(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
